// File: rtl/clock_period_meter.sv
// clock_period_meter
//   Measures the period and high time of a slow, asynchronous square wave in
//   cycles of clock_in. One result is reported per input period. An input that
//   stops producing rising edges is flagged as stalled.
//
// Ports
//   clock_in    system clock, all logic on its rising edge
//   reset_n     asynchronous active-low reset
//   signal_in   asynchronous square wave to measure
//   enable      measurement enable (level)
//   period_out  last measured period, in clock_in cycles
//   high_out    last measured high time, in clock_in cycles
//   valid       one-cycle pulse when period_out/high_out update
//   stalled     no rising edge for TIMEOUT cycles while armed/measuring
module clock_period_meter #(
    parameter int          WIDTH       = 28,
    parameter int unsigned TIMEOUT     = 100000000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             signal_in,
    input  logic             enable,
    output logic [WIDTH-1:0] period_out,
    output logic [WIDTH-1:0] high_out,
    output logic             valid,
    output logic             stalled
);

    localparam logic [WIDTH-1:0] TIMEOUT_C = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] ONE_C     = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sdly_q, sdly_d;
    logic [WIDTH-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       hcnt_q, hcnt_d;
    logic [WIDTH-1:0]       period_q, period_d;
    logic [WIDTH-1:0]       high_q, high_d;
    logic                   valid_q, valid_d;
    logic                   stalled_q, stalled_d;

    logic s, rise, timeout;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~sdly_q;
    // cnt doubles as the watchdog: in ARM it counts from entry, in MEASURE
    // it counts from the last rise, so one compare covers both states.
    assign timeout = (cnt_q == TIMEOUT_C);

    // State register
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; enable low overrides everything, rise beats timeout
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = ARM;
                ARM:     if (rise) state_d = MEASURE;
                MEASURE: if (!rise && timeout) state_d = ARM;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath / output next values
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], signal_in};
        sdly_d    = s;
        cnt_d     = cnt_q;
        hcnt_d    = hcnt_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        stalled_d = stalled_q;
        if (!enable) begin
            // Results are held; the in-flight period is dropped.
            cnt_d     = '0;
            hcnt_d    = '0;
            stalled_d = 1'b0;
        end else begin
            case (state_q)
                ARM: begin
                    if (rise) begin
                        cnt_d  = ONE_C;
                        hcnt_d = ONE_C;
                    end else if (timeout) begin
                        cnt_d     = '0;
                        hcnt_d    = '0;
                        stalled_d = 1'b1;
                        period_d  = '0;
                        high_d    = '0;
                    end else begin
                        cnt_d = cnt_q + ONE_C;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_d  = cnt_q;
                        high_d    = hcnt_q;
                        valid_d   = 1'b1;
                        stalled_d = 1'b0;
                        cnt_d     = ONE_C;
                        hcnt_d    = ONE_C;
                    end else if (timeout) begin
                        cnt_d     = '0;
                        hcnt_d    = '0;
                        stalled_d = 1'b1;
                        period_d  = '0;
                        high_d    = '0;
                    end else begin
                        cnt_d  = cnt_q + ONE_C;
                        hcnt_d = hcnt_q + WIDTH'(s);
                    end
                end
                default: begin
                    cnt_d  = '0;
                    hcnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= '0;
            sdly_q    <= 1'b0;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            stalled_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            sdly_q    <= sdly_d;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            stalled_q <= stalled_d;
        end
    end

    assign period_out = period_q;
    assign high_out   = high_q;
    assign valid      = valid_q;
    assign stalled    = stalled_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Scoreboard bench for clock_period_meter. The stimulus process drives a
// square wave period by period and pushes what each completed period must
// report; a monitor on the falling clock edge pops and compares every
// valid pulse, stalled assertion and disable.
module tb_clock_period_meter;

    localparam int WIDTH   = 28;
    localparam int TIMEOUT = 100;
    localparam int SYNC    = 2;

    localparam int K_VALID = 0;
    localparam int K_STALL = 1;
    localparam int K_DIS   = 2;

    logic             clock_in  = 1'b0;
    logic             reset_n   = 1'b0;
    logic             signal_in = 1'b0;
    logic             enable    = 1'b0;
    logic [WIDTH-1:0] period_out;
    logic [WIDTH-1:0] high_out;
    logic             valid;
    logic             stalled;

    clock_period_meter #(
        .WIDTH      (WIDTH),
        .TIMEOUT    (TIMEOUT),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clock_in  (clock_in),
        .reset_n   (reset_n),
        .signal_in (signal_in),
        .enable    (enable),
        .period_out(period_out),
        .high_out  (high_out),
        .valid     (valid),
        .stalled   (stalled)
    );

    always #5 clock_in = ~clock_in;

    typedef struct {
        int kind;
        int per;
        int hi;
        int gap;   // cycles since the previous valid, 0 = not checked
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // reference model state: rises/valids seen in the current armed session
    int sess_rises  = 0;
    int sess_valids = 0;
    int prev_h      = 0;
    int prev_l      = 0;
    int held_p      = 0;
    int held_h      = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic push(input int kind, input int per, input int hi, input int gap);
        exp_t e;
        e.kind = kind;
        e.per  = per;
        e.hi   = hi;
        e.gap  = gap;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock_in);
            #1;
        end
    endtask

    // A rise completes the previous period of this session, if there is one.
    task automatic rise_start();
        if (sess_rises > 0) begin
            push(K_VALID, prev_h + prev_l, prev_h,
                 (sess_valids > 0) ? prev_h + prev_l : 0);
            sess_valids++;
            held_p = prev_h + prev_l;
            held_h = prev_h;
        end
        sess_rises++;
        signal_in = 1'b1;
    endtask

    task automatic drive_period(input int h, input int l);
        rise_start();
        tick(h);
        signal_in = 1'b0;
        tick(l);
        prev_h = h;
        prev_l = l;
    endtask

    task automatic do_stall();
        push(K_STALL, 0, 0, TIMEOUT);
        held_p = 0;
        held_h = 0;
        signal_in = 1'b0;
        tick(TIMEOUT + 10);
        sess_rises  = 0;
        sess_valids = 0;
    endtask

    task automatic do_disable();
        enable = 1'b0;
        push(K_DIS, held_p, held_h, 0);
        sess_rises  = 0;
        sess_valids = 0;
        for (int i = 0; i < 10; i++) begin
            signal_in = 1'($urandom_range(0, 1));
            tick(1);
        end
        signal_in = 1'b0;
        tick(5);
        enable = 1'b1;
        tick(4);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) tick(1);
        chk("drain", q.size(), 0);
        q.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_period"},  int'(period_out), 0);
        chk({tag, "_high"},    int'(high_out), 0);
        chk({tag, "_valid"},   int'(valid), 0);
        chk({tag, "_stalled"}, int'(stalled), 0);
    endtask

    // ---------------- monitor ----------------
    int   m_cyc    = 0;
    int   m_last_v = 0;
    int   m_en_lo  = 0;
    logic m_stl_p  = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clock_in);
            m_cyc++;
            if (!reset_n) begin
                m_stl_p = 1'b0;
                m_en_lo = 0;
            end else begin
                m_en_lo = enable ? 0 : m_en_lo + 1;
                if (valid) begin
                    if (q.size() == 0) begin
                        n_chk++;
                        $display("FAIL spurious_valid: got period=%0d high=%0d, expected no output",
                                 period_out, high_out);
                    end else begin
                        e = q.pop_front();
                        chk("valid_kind", K_VALID, e.kind);
                        chk("period", int'(period_out), e.per);
                        chk("high", int'(high_out), e.hi);
                        chk("stalled_on_valid", int'(stalled), 0);
                        if (e.gap > 0) chk("valid_spacing", m_cyc - m_last_v, e.gap);
                    end
                    m_last_v = m_cyc;
                end
                if (stalled && !m_stl_p) begin
                    if (q.size() == 0) begin
                        n_chk++;
                        $display("FAIL spurious_stall: got stalled=1, expected 0");
                    end else begin
                        e = q.pop_front();
                        chk("stall_kind", K_STALL, e.kind);
                        chk("stall_period", int'(period_out), e.per);
                        chk("stall_high", int'(high_out), e.hi);
                        chk("stall_delay", m_cyc - m_last_v, e.gap);
                    end
                end
                if (m_en_lo == 2) begin
                    if (q.size() == 0) begin
                        n_chk++;
                        $display("FAIL disable_event: got disable with no expected entry, expected entry");
                    end else begin
                        e = q.pop_front();
                        chk("disable_kind", K_DIS, e.kind);
                        chk("disable_hold_period", int'(period_out), e.per);
                        chk("disable_hold_high", int'(high_out), e.hi);
                        chk("disable_stalled", int'(stalled), 0);
                    end
                end
                m_stl_p = stalled;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        #12;
        chk_zero("reset");
        @(posedge clock_in);
        #1;
        reset_n = 1'b1;
        enable  = 1'b1;
        tick(4);

        // divided clock, divisor 10 then 7
        repeat (4) drive_period(5, 5);
        repeat (4) drive_period(4, 3);

        // live switch from divisor 10 to 20
        repeat (3) drive_period(5, 5);
        repeat (3) drive_period(10, 10);

        // stall after lock, then restart
        repeat (3) drive_period(5, 5);
        do_stall();
        repeat (3) drive_period(5, 5);

        // drop enable mid-period
        rise_start();
        tick(5);
        signal_in = 1'b0;
        tick(2);
        do_disable();
        repeat (3) drive_period(5, 5);

        // random periods with occasional disables
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                signal_in = 1'b0;
                tick(4);
                do_disable();
            end
            drive_period($urandom_range(1, 12), $urandom_range(1, 12));
        end

        // asynchronous reset in MEASURE
        repeat (2) drive_period(5, 5);
        rise_start();
        tick(6);
        wait_drain();
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("async_reset");
        signal_in   = 1'b0;
        sess_rises  = 0;
        sess_valids = 0;
        held_p      = 0;
        held_h      = 0;
        tick(2);
        chk_zero("reset_hold");
        reset_n = 1'b1;
        tick(4);
        repeat (4) drive_period(5, 5);

        signal_in = 1'b0;
        tick(10);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
